// File: rtl/fa_nand_pkg.sv
// rtl/fa_nand_pkg.sv - shared NAND primitive, reset value and default width for fa_nand
package fa_nand_pkg;

  localparam int   FA_NAND_WIDTH   = 1;
  localparam logic FA_NAND_RST_VAL = 1'b0;

  // The only logic primitive allowed in the adder datapath
  function automatic logic nd(input logic x, input logic y);
    return ~(x & y);
  endfunction

endpackage

// File: rtl/fa_nand_bit.sv
// rtl/fa_nand_bit.sv - one full-adder bit cell built from nine NAND2 gates
module fa_nand_bit
  import fa_nand_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic n1, n2, n3, x, n5, n6, n7;

  // First half adder: x = a ^ b, n1 doubles as the a&b term for the carry
  assign n1 = nd(a, b);
  assign n2 = nd(a, n1);
  assign n3 = nd(b, n1);
  assign x  = nd(n2, n3);

  // Second half adder folds in the carry; co = (a&b) | (x&ci)
  assign n5 = nd(x, ci);
  assign n6 = nd(x, n5);
  assign n7 = nd(ci, n5);
  assign s  = nd(n6, n7);
  assign co = nd(n5, n1);

endmodule

// File: rtl/fa_nand.sv
// rtl/fa_nand.sv - NAND-only ripple-carry adder with registered outputs (FA_NAND_COMB_OUT_EN removes the register)
module fa_nand
  import fa_nand_pkg::*;
#(
  parameter int WIDTH = FA_NAND_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cy
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;

  assign carry[0] = c;

  // Ripple chain: each cell's carry-out feeds the next cell's carry-in
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_nand_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

`ifdef FA_NAND_COMB_OUT_EN
  // Zero-latency build: clk and rst_n stay on the port list but have no effect
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign sum = sum_d;
  assign cy  = carry[WIDTH];
`else
  // Output register, cleared asynchronously so reset takes effect without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= {WIDTH{FA_NAND_RST_VAL}};
      cy  <= FA_NAND_RST_VAL;
    end else begin
      sum <= sum_d;
      cy  <= carry[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_fa_nand.sv
// tb/tb_fa_nand.sv - directed-vector bench for fa_nand at WIDTH=1 and WIDTH=4
module tb_fa_nand;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a1, b1;
  logic       c1;
  logic [0:0] sum1;
  logic       cy1;
  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] sum4;
  logic       cy4;

  int n_tests = 0;
  int n_fail  = 0;

  // Truth table indexed by {a,b,c}
  logic [7:0] sum_tab = 8'b1001_0110;
  logic [7:0] cy_tab  = 8'b1110_1000;

  always #5 clk = ~clk;

  fa_nand #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a1),
    .b     (b1),
    .c     (c1),
    .sum   (sum1),
    .cy    (cy1)
  );

  fa_nand #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .b     (b4),
    .c     (c4),
    .sum   (sum4),
    .cy    (cy4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

`ifdef FA_NAND_COMB_OUT_EN
    // Zero-latency build: outputs follow inputs with no clock involvement
    for (int v = 0; v < 8; v++) begin
      {a1, b1, c1} = v[2:0];
      #1;
      check($sformatf("comb_sum_%0d", v), {7'd0, sum1}, {7'd0, sum_tab[v]});
      check($sformatf("comb_cy_%0d", v),  {7'd0, cy1},  {7'd0, cy_tab[v]});
      #9;
    end
    a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; #1;
    check("comb_w4_a", {3'd0, cy4, sum4}, 8'h10);
    a4 = 4'h5; b4 = 4'hA; c4 = 1'b1; #1;
    check("comb_w4_b", {3'd0, cy4, sum4}, 8'h10);
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; #1;
    check("comb_w4_c", {3'd0, cy4, sum4}, 8'h07);
`else
    // Scenario 1: reset held with clock running keeps outputs clear
    #1;
    check("rst_t0_w1", {6'd0, cy1, sum1}, 8'h00);
    check("rst_t0_w4", {3'd0, cy4, sum4}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_hold_%0d", k), {6'd0, cy1, sum1}, 8'h00);
    end
    rst_n = 1'b1;

    // Scenario 2: exhaustive sweep, result visible after the sampling edge
    for (int v = 0; v < 8; v++) begin
      {a1, b1, c1} = v[2:0];
      tick();
      check($sformatf("sweep_sum_%0d", v), {7'd0, sum1}, {7'd0, sum_tab[v]});
      check($sformatf("sweep_cy_%0d", v),  {7'd0, cy1},  {7'd0, cy_tab[v]});
    end

    // Scenario 3: one-cycle latency
    {a1, b1, c1} = 3'b000;
    tick();
    check("lat_zero", {6'd0, cy1, sum1}, 8'h00);
    {a1, b1, c1} = 3'b110;
    #3;
    check("lat_before_edge", {6'd0, cy1, sum1}, 8'h00);
    tick();
    check("lat_after_edge", {6'd0, cy1, sum1}, 8'h02);

    // Scenario 4: asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clear", {6'd0, cy1, sum1}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("async_rst_no_edge", {6'd0, cy1, sum1}, 8'h00);
    tick();
    check("async_rst_restore", {6'd0, cy1, sum1}, 8'h02);

    // Scenario 6: WIDTH=4 ripple carry through all bits
    a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
    tick();
    check("w4_f_plus_1", {3'd0, cy4, sum4}, 8'h10);
    a4 = 4'h5; b4 = 4'hA; c4 = 1'b1;
    tick();
    check("w4_5_a_c1", {3'd0, cy4, sum4}, 8'h10);
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
    tick();
    check("w4_3_plus_4", {3'd0, cy4, sum4}, 8'h07);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
